pixel_stream_receiver: RTL and testbench

- Consumer end of the rasterizer pixel stream: accepts the 4-bit pixel nibble plus frame_sync produced by the GPU command processor.
- Reassembles each 8x8 frame into a double-buffered frame store and exposes the last complete frame on a registered random-access read port.
- Used as the on-chip loopback checker and as the capture side of an external display/host bridge.

---
 rtl/pixel_stream_receiver.sv | 178 +++++++++++++++++
 tb/tb_pixel_stream_receiver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_receiver.sv
// Pixel stream receiver: reassembles raster-order pixels into a double-buffered frame
// store with a registered read port. Optional frame checksum output under PIXEL_CHECKSUM_EN.
module pixel_stream_receiver #(
    parameter int FB_W  = 8,
    parameter int FB_H  = 8,
    parameter int PIX_W = 4,
    parameter int NPIX  = FB_W * FB_H,
    parameter int AW    = $clog2(NPIX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             sync_in,
    input  logic [AW-1:0]    rd_addr,
    output logic [PIX_W-1:0] rd_data,
    output logic             frame_valid,
    output logic             frame_done,
    output logic             sync_err,
    output logic [7:0]       frame_cnt,
`ifdef PIXEL_CHECKSUM_EN
    output logic [7:0]       frame_sum,
`endif
    output logic             busy
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NPIX - 1);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_CAPTURE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [AW-1:0]    r_pix_idx;
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic             r_frame_valid;
    logic             r_frame_done;
    logic             r_sync_err;
    logic [7:0]       r_frame_cnt;
    logic [PIX_W-1:0] r_rd_data;

    // Two banks back to back; the bank bit is the MSB of the store address.
    logic [PIX_W-1:0] r_mem [0:2*NPIX-1];

    logic          w_wr_en;
    logic [AW-1:0] w_wr_idx;
    logic          w_last;
    logic          w_abort;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (pix_valid && sync_in) begin
                    w_state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (w_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (r_state == S_CAPTURE);
    end

    // A sync pixel always restarts at index 0, whether from IDLE or mid-capture.
    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_idx = r_pix_idx;
        w_last   = 1'b0;
        w_abort  = 1'b0;
        if (pix_valid && !rst) begin
            if (sync_in) begin
                w_wr_en  = 1'b1;
                w_wr_idx = '0;
                w_abort  = (r_state == S_CAPTURE);
            end else if (r_state == S_CAPTURE) begin
                w_wr_en = 1'b1;
                w_last  = (r_pix_idx == LAST_IDX);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_idx     <= '0;
            r_wr_bank     <= 1'b0;
            r_rd_bank     <= 1'b1;
            r_frame_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            r_sync_err    <= 1'b0;
            r_frame_cnt   <= 8'd0;
        end else begin
            r_frame_done <= w_last;
            r_sync_err   <= w_abort;
            if (w_wr_en) begin
                if (sync_in) begin
                    r_pix_idx <= AW'(1);
                end else if (w_last) begin
                    r_pix_idx <= '0;
                end else begin
                    r_pix_idx <= r_pix_idx + 1'b1;
                end
            end
            if (w_last) begin
                r_wr_bank     <= ~r_wr_bank;
                r_rd_bank     <= ~r_rd_bank;
                r_frame_valid <= 1'b1;
                r_frame_cnt   <= r_frame_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[{r_wr_bank, w_wr_idx}] <= pix_in;
        end
    end

    // Registered read with synchronous clear; gated to zero until a frame exists.
    always_ff @(posedge clk) begin
        if (rst || !r_frame_valid) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[{r_rd_bank, rd_addr}];
        end
    end

`ifdef PIXEL_CHECKSUM_EN
    logic [7:0] r_acc;
    logic [7:0] r_frame_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= 8'd0;
            r_frame_sum <= 8'd0;
        end else if (w_wr_en) begin
            if (sync_in) begin
                r_acc <= 8'(pix_in);
            end else begin
                r_acc <= r_acc + 8'(pix_in);
            end
            if (w_last) begin
                r_frame_sum <= r_acc + 8'(pix_in);
            end
        end
    end

    assign frame_sum = r_frame_sum;
`endif

    assign rd_data     = r_rd_data;
    assign frame_valid = r_frame_valid;
    assign frame_done  = r_frame_done;
    assign sync_err    = r_sync_err;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_pixel_stream_receiver.sv
// Self-checking bench for pixel_stream_receiver: table-driven frame vectors, read-port
// scoreboard, and hand-written sequences for gaps, aborts, reset and counter wrap.
module tb_pixel_stream_receiver;

    localparam int NPIX = 64;
    localparam int AW   = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pix_valid = 1'b0;
    logic [3:0]    pix_in = 4'h0;
    logic          sync_in = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [3:0]    rd_data;
    logic          frame_valid;
    logic          frame_done;
    logic          sync_err;
    logic [7:0]    frame_cnt;
    logic          busy;
`ifdef PIXEL_CHECKSUM_EN
    logic [7:0]    frame_sum;
`endif

    pixel_stream_receiver dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_in     (pix_in),
        .sync_in    (sync_in),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_valid(frame_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .frame_cnt  (frame_cnt),
`ifdef PIXEL_CHECKSUM_EN
        .frame_sum  (frame_sum),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_done = 0;
    int n_serr = 0;

    always @(negedge clk) begin
        if (frame_done) n_done <= n_done + 1;
        if (sync_err)   n_serr <= n_serr + 1;
    end

    logic [3:0] exp_q[$];

    typedef struct {
        int         n_lead;
        logic [3:0] fill;
        bit         ramp;
        logic [7:0] exp_cnt;
        logic [7:0] exp_sum;
    } vec_t;

    vec_t vecs[3];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic send_pix(input logic [3:0] v, input logic s);
        pix_valid = 1'b1;
        pix_in    = v;
        sync_in   = s;
        step();
        pix_valid = 1'b0;
        sync_in   = 1'b0;
    endtask

    task automatic check_sum(input string name, input logic [7:0] exp);
`ifdef PIXEL_CHECKSUM_EN
        chk(name, {24'd0, frame_sum}, {24'd0, exp});
`else
        if (exp == 8'hFF && frame_cnt == 8'hFF) $display("sum check %s skipped", name);
`endif
    endtask

    task automatic read_sweep(input string name, input logic [3:0] fill, input bit ramp);
        logic [3:0] e;
        for (int a = 0; a < NPIX; a++) begin
            rd_addr = AW'(a);
            exp_q.push_back(ramp ? a[3:0] : fill);
            step();
            e = exp_q.pop_front();
            chk(name, {28'd0, rd_data}, {28'd0, e});
        end
    endtask

    initial begin
        int d0, s0, sent;
        bit v;
        logic [3:0] e;

        vecs[0] = '{n_lead: 0, fill: 4'h0, ramp: 1'b1, exp_cnt: 8'd1, exp_sum: 8'hE0};
        vecs[1] = '{n_lead: 5, fill: 4'h7, ramp: 1'b0, exp_cnt: 8'd2, exp_sum: 8'hC0};
        vecs[2] = '{n_lead: 0, fill: 4'h3, ramp: 1'b0, exp_cnt: 8'd3, exp_sum: 8'hC0};

        repeat (3) step();
        rst = 1'b0;
        chk("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_sync_err", {31'd0, sync_err}, 32'd0);
        chk("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rd_data", {28'd0, rd_data}, 32'd0);
        check_sum("rst_sum", 8'h00);
        rd_addr = 6'd0;
        exp_q.push_back(4'h0);
        step();
        e = exp_q.pop_front();
        chk("rd_before_frame", {28'd0, rd_data}, {28'd0, e});

        for (int vi = 0; vi < 3; vi++) begin
            s0 = n_serr;
            d0 = n_done;
            for (int k = 0; k < vecs[vi].n_lead; k++) send_pix(4'h1, 1'b0);
            chk("lead_busy", {31'd0, busy}, 32'd0);
            for (int i = 0; i < NPIX; i++) begin
                send_pix(vecs[vi].ramp ? i[3:0] : vecs[vi].fill, i == 0);
                if (i == NPIX - 2) begin
                    chk("early_done", {31'd0, frame_done}, 32'd0);
                    chk("capture_busy", {31'd0, busy}, 32'd1);
                end
            end
            chk("done_latency", {31'd0, frame_done}, 32'd1);
            chk("vec_frame_valid", {31'd0, frame_valid}, 32'd1);
            chk("vec_frame_cnt", {24'd0, frame_cnt}, {24'd0, vecs[vi].exp_cnt});
            chk("idle_after_frame", {31'd0, busy}, 32'd0);
            check_sum("vec_sum", vecs[vi].exp_sum);
            read_sweep("vec_rd", vecs[vi].fill, vecs[vi].ramp);
            chk("vec_done_count", n_done - d0, 32'd1);
            chk("vec_no_sync_err", n_serr - s0, 32'd0);
            $display("vector %0d: frame_cnt=%0d done_pulses=%0d", vi, frame_cnt, n_done - d0);
        end

        // Frame B with valid toggling; addr 10 read every cycle across the swap.
        sent = 0;
        d0 = n_done;
        for (int i = 0; i < 130; i++) begin
            v = (i % 2 == 0) && (sent < NPIX);
            rd_addr = 6'd10;
            exp_q.push_back(sent == NPIX ? 4'hC : 4'h3);
            pix_valid = v;
            pix_in    = 4'hC;
            sync_in   = v && (sent == 0);
            step();
            pix_valid = 1'b0;
            sync_in   = 1'b0;
            if (v) sent++;
            e = exp_q.pop_front();
            chk("swap_rd10", {28'd0, rd_data}, {28'd0, e});
            chk("swap_done", {31'd0, frame_done}, {31'd0, (v && sent == NPIX)});
        end
        chk("swap_frame_cnt", {24'd0, frame_cnt}, 32'd4);
        chk("swap_done_count", n_done - d0, 32'd1);
        $display("toggle frame: frame_cnt=%0d", frame_cnt);

        // Abort after 20 pixels, then a full frame of 5.
        s0 = n_serr;
        d0 = n_done;
        for (int i = 0; i < 20; i++) send_pix(4'h9, i == 0);
        send_pix(4'h5, 1'b1);
        chk("abort_sync_err", {31'd0, sync_err}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd1);
        chk("abort_cnt_kept", {24'd0, frame_cnt}, 32'd4);
        for (int i = 1; i < NPIX; i++) send_pix(4'h5, 1'b0);
        chk("abort_done", {31'd0, frame_done}, 32'd1);
        chk("abort_frame_cnt", {24'd0, frame_cnt}, 32'd5);
        check_sum("abort_sum", 8'h40);
        read_sweep("abort_rd", 4'h5, 1'b0);
        chk("abort_serr_count", n_serr - s0, 32'd1);
        chk("abort_done_count", n_done - d0, 32'd1);
        $display("abort frame: sync_err_pulses=%0d frame_cnt=%0d", n_serr - s0, frame_cnt);

        // Reset at pixel 30 of a frame.
        for (int i = 0; i < 30; i++) send_pix(4'hE, i == 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_frame_valid", {31'd0, frame_valid}, 32'd0);
        chk("mrst_rd_data", {28'd0, rd_data}, 32'd0);
        chk("mrst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        check_sum("mrst_sum", 8'h00);
        rd_addr = 6'd3;
        exp_q.push_back(4'h0);
        step();
        e = exp_q.pop_front();
        chk("mrst_rd_gated", {28'd0, rd_data}, {28'd0, e});
        for (int i = 0; i < NPIX; i++) send_pix(4'hA, i == 0);
        chk("mrst_after_cnt", {24'd0, frame_cnt}, 32'd1);
        check_sum("mrst_after_sum", 8'h80);
        read_sweep("mrst_rd", 4'hA, 1'b0);
        $display("reset recovery: frame_cnt=%0d", frame_cnt);

        // 256 back-to-back frames from reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        s0 = n_serr;
        d0 = n_done;
        for (int f = 0; f < 256; f++) begin
            for (int i = 0; i < NPIX; i++) send_pix(f[3:0], i == 0);
            if (f == 254) chk("wrap_cnt_255", {24'd0, frame_cnt}, 32'd255);
        end
        chk("wrap_cnt_0", {24'd0, frame_cnt}, 32'd0);
        chk("wrap_last_done", {31'd0, frame_done}, 32'd1);
        check_sum("wrap_sum", 8'hC0);
        step();
        chk("wrap_done_count", n_done - d0, 32'd256);
        chk("wrap_no_sync_err", n_serr - s0, 32'd0);
        read_sweep("wrap_rd", 4'hF, 1'b0);
        $display("back-to-back: done_pulses=%0d frame_cnt=%0d", n_done - d0, frame_cnt);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
